// File: rtl/ernic_tx_pkg.sv
// Shared types and helpers for the ERNIC TX packet arbiter.
package ernic_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Upper bound on channel count; rr_select works on vectors of this width.
    localparam int MAX_CH     = 8;
    localparam int DEF_DATA_W = 512;
    localparam int KEEP_W     = DEF_DATA_W / 8;

    // Returns the first requester found searching upward from ptr+1, modulo num_ch.
    // When nobody requests, the pointer itself is returned unchanged.
    function automatic logic [2:0] rr_select(input logic [MAX_CH-1:0] req,
                                             input logic [2:0]        ptr,
                                             input int                num_ch);
        logic [2:0] sel;
        logic [2:0] idx;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            if (k <= num_ch && !found) begin
                idx = 3'((int'(ptr) + k) % num_ch);
                if (req[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ernic_tx_pkt_arb_slice.sv
// One-beat AXI-Stream register slice driving the arbiter output.
module axis_reg_slice #(
    parameter int DATA_W = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_keep,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_W-1:0]     m_data,
    output logic [DATA_W/8-1:0]   m_keep,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign s_ready = !m_valid || m_ready;

    // Load on input handshake; otherwise empty the slot once downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (s_valid && s_ready) begin
            m_data  <= s_data;
            m_keep  <= s_keep;
            m_valid <= 1'b1;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ernic_tx_pkt_arb.sv
// N-channel packet-locked round-robin AXI-Stream arbiter with truncation and stats.
module ernic_tx_pkt_arb
    import ernic_tx_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 512,
    parameter int MAX_BEATS = 144,
    parameter int CNT_W     = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_CH*DATA_W-1:0]    s_axis_tdata,
    input  logic [NUM_CH*DATA_W/8-1:0]  s_axis_tkeep,
    input  logic [NUM_CH-1:0]           s_axis_tvalid,
    input  logic [NUM_CH-1:0]           s_axis_tlast,
    output logic [NUM_CH-1:0]           s_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic [DATA_W/8-1:0]         m_axis_tkeep,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [$clog2(NUM_CH)-1:0]   grant_ch,
    output logic [CNT_W-1:0]            tx_pkt_cnt,
    output logic [15:0]                 trunc_cnt
);

    localparam int KW = DATA_W / 8;
    localparam int GW = $clog2(NUM_CH);
    localparam int BW = $clog2(MAX_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    arb_state_t       state_q, state_nxt;
    logic [GW-1:0]    grant_q, grant_nxt;
    logic [GW-1:0]    ptr_q, ptr_nxt;
    logic [BW-1:0]    beat_q, beat_nxt;
    logic [15:0]      trunc_q;
    logic             trunc_inc;

    logic [DATA_W-1:0] sel_data;
    logic [KW-1:0]     sel_keep;
    logic              sel_valid;
    logic              sel_last;

    logic [MAX_CH-1:0] req_ext;
    logic [2:0]        ptr_ext;
    logic [2:0]        pick_ext;
    logic [GW-1:0]     pick;

    logic              fwd_valid;
    logic              fwd_last;
    logic              slice_ready;

    // Route the granted channel's stream onto a single set of signals.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
                sel_keep  = s_axis_tkeep[i*KW +: KW];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Round-robin choice among the channels currently presenting tvalid.
    always_comb begin
        req_ext               = '0;
        req_ext[NUM_CH-1:0]   = s_axis_tvalid;
        ptr_ext               = '0;
        ptr_ext[GW-1:0]       = ptr_q;
        pick_ext              = rr_select(req_ext, ptr_ext, NUM_CH);
        pick                  = pick_ext[GW-1:0];
    end

    // Arbitration FSM: grant in IDLE, forward with a lock in FWD, discard the oversize tail in DRAIN.
    always_comb begin
        state_nxt     = state_q;
        grant_nxt     = grant_q;
        ptr_nxt       = ptr_q;
        beat_nxt      = beat_q;
        s_axis_tready = '0;
        fwd_valid     = 1'b0;
        trunc_inc     = 1'b0;
        fwd_last      = sel_last || (beat_q == LAST_BEAT);
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    state_nxt = FWD;
                    grant_nxt = pick;
                    ptr_nxt   = pick;
                    beat_nxt  = '0;
                end
            end
            FWD: begin
                s_axis_tready[grant_q] = slice_ready;
                fwd_valid              = sel_valid;
                if (sel_valid && slice_ready) begin
                    if (sel_last) begin
                        state_nxt = IDLE;
                    end else if (beat_q == LAST_BEAT) begin
                        state_nxt = DRAIN;
                        trunc_inc = 1'b1;
                    end else begin
                        beat_nxt = beat_q + BW'(1);
                    end
                end
            end
            DRAIN: begin
                s_axis_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, grant and pointer registers; the pointer starts at the top so channel 0 wins first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= GW'(NUM_CH - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            ptr_q   <= ptr_nxt;
            beat_q  <= beat_nxt;
        end
    end

    // Statistics: emitted packets wrap, truncated packets saturate.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_pkt_cnt <= '0;
            trunc_q    <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
            end
            if (trunc_inc && trunc_q != 16'hFFFF) begin
                trunc_q <= trunc_q + 16'd1;
            end
        end
    end

    assign grant_ch  = grant_q;
    assign trunc_cnt = trunc_q;

    axis_reg_slice #(
        .DATA_W (DATA_W)
    ) u_out_slice (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_data  (sel_data),
        .s_keep  (sel_keep),
        .s_valid (fwd_valid),
        .s_last  (fwd_last),
        .s_ready (slice_ready),
        .m_data  (m_axis_tdata),
        .m_keep  (m_axis_tkeep),
        .m_valid (m_axis_tvalid),
        .m_last  (m_axis_tlast),
        .m_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_ernic_tx_pkt_arb.sv
// Self-checking bench for ernic_tx_pkt_arb using a packet-level round-robin model.
module tb_ernic_tx_pkt_arb;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 32;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = 32;
    localparam int GW        = 2;
    localparam int MAXP      = 8;

    logic                        aclk;
    logic                        aresetn;
    logic [NUM_CH*DATA_W-1:0]    s_axis_tdata;
    logic [NUM_CH*KEEP_W-1:0]    s_axis_tkeep;
    logic [NUM_CH-1:0]           s_axis_tvalid;
    logic [NUM_CH-1:0]           s_axis_tlast;
    logic [NUM_CH-1:0]           s_axis_tready;
    logic [DATA_W-1:0]           m_axis_tdata;
    logic [KEEP_W-1:0]           m_axis_tkeep;
    logic                        m_axis_tvalid;
    logic                        m_axis_tlast;
    logic                        m_axis_tready;
    logic [GW-1:0]               grant_ch;
    logic [CNT_W-1:0]            tx_pkt_cnt;
    logic [15:0]                 trunc_cnt;

    ernic_tx_pkt_arb #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_ch      (grant_ch),
        .tx_pkt_cnt    (tx_pkt_cnt),
        .trunc_cnt     (trunc_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    out_cyc[$];
    int    grant_seen[$];

    int checks   = 0;
    int failures = 0;

    int npk[NUM_CH];
    int plen[NUM_CH][MAXP];
    int cur_pkt[NUM_CH];
    int cur_beat[NUM_CH];
    int start_cyc[NUM_CH];
    int gap_pct;
    int rdy_mode;
    int cyc;
    int pid_base;
    int exp_pkts;
    int exp_trunc;
    int first_valid_cyc;
    int lock_err;
    int stab_err;
    int stall_cycles;
    bit rdy_pat[4];
    int exp_g[5];

    // Unique per-beat payload: channel, packet number and beat number.
    function automatic logic [DATA_W-1:0] mk_data(input int c, input int p, input int b);
        return {8'(c), 8'(p + pid_base), 16'(b)};
    endfunction

    function automatic logic [KEEP_W-1:0] mk_keep(input int c, input int b);
        return KEEP_W'(((c * 3 + b) % 15) + 1);
    endfunction

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void clear_traffic();
        for (int c = 0; c < NUM_CH; c++) begin
            npk[c]       = 0;
            cur_pkt[c]   = 0;
            cur_beat[c]  = 0;
            start_cyc[c] = 0;
        end
        exp_q.delete();
        out_cyc.delete();
        grant_seen.delete();
        exp_pkts        = 0;
        exp_trunc       = 0;
        first_valid_cyc = -1;
        lock_err        = 0;
        stab_err        = 0;
        stall_cycles    = 0;
        gap_pct         = 0;
        rdy_mode        = 0;
        pid_base        = 0;
    endfunction

    function automatic void add_pkt(input int c, input int len);
        plen[c][npk[c]] = len;
        npk[c]++;
    endfunction

    // Packet-level reference: round-robin over channels that still hold packets,
    // whole packets at a time, each cut to MAX_BEATS with a forced last.
    function automatic void build_model();
        int rem[NUM_CH];
        int total;
        int ptr;
        int c;
        int len;
        int nb;
        int p;
        beat_t bt;
        total = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rem[i] = npk[i];
            total += npk[i];
        end
        ptr = NUM_CH - 1;
        while (total > 0) begin
            c = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                if (c < 0 && rem[(ptr + k) % NUM_CH] > 0) c = (ptr + k) % NUM_CH;
            end
            p   = npk[c] - rem[c];
            len = plen[c][p];
            nb  = (len > MAX_BEATS) ? MAX_BEATS : len;
            for (int b = 0; b < nb; b++) begin
                bt.data = mk_data(c, p, b);
                bt.keep = mk_keep(c, b);
                bt.last = (b == nb - 1);
                exp_q.push_back(bt);
            end
            exp_pkts++;
            if (len > MAX_BEATS) exp_trunc++;
            rem[c]--;
            total--;
            ptr = c;
        end
    endfunction

    // Present each source's current beat; a waiting packet head always holds tvalid.
    function automatic void drive_inputs();
        logic v;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cyc >= start_cyc[c] && cur_pkt[c] < npk[c]) begin
                v = (cur_beat[c] == 0) || (int'($urandom_range(99)) >= gap_pct);
                s_axis_tvalid[c] = v;
                s_axis_tdata[c*DATA_W +: DATA_W] = mk_data(c, cur_pkt[c], cur_beat[c]);
                s_axis_tkeep[c*KEEP_W +: KEEP_W] = mk_keep(c, cur_beat[c]);
                s_axis_tlast[c] = (cur_beat[c] == plen[c][cur_pkt[c]] - 1);
            end else begin
                s_axis_tvalid[c] = 1'b0;
                s_axis_tdata[c*DATA_W +: DATA_W] = '0;
                s_axis_tkeep[c*KEEP_W +: KEEP_W] = '0;
                s_axis_tlast[c] = 1'b0;
            end
        end
        if (rdy_mode == 0)      m_axis_tready = 1'b1;
        else if (rdy_mode == 1) m_axis_tready = rdy_pat[cyc % 4];
        else                    m_axis_tready = 1'($urandom_range(1));
    endfunction

    function automatic bit traffic_done();
        bit d;
        d = (exp_q.size() == 0);
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_pkt[c] < npk[c]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic check_beat(input beat_t got);
        beat_t e;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", {32'd0, got.data}, 64'hDEAD);
        end else begin
            e = exp_q.pop_front();
            checkOutput("out_data", got.data, e.data);
            checkOutput("out_keep", got.keep, e.keep);
            checkOutput("out_last", got.last, e.last);
        end
    endtask

    // Runs the source drivers and output monitor cycle by cycle until the model is drained.
    task automatic applyStimulus(input int max_cycles, input bit require_done);
        logic [NUM_CH-1:0] s_hs;
        bit    m_hs;
        bit    prev_stall;
        beat_t got;
        beat_t prev;
        cyc        = 0;
        prev_stall = 1'b0;
        drive_inputs();
        while (cyc < max_cycles && !traffic_done()) begin
            @(negedge aclk);
            s_hs = s_axis_tvalid & s_axis_tready;
            if ((s_axis_tready & ~(NUM_CH'(1) << grant_ch)) != '0) lock_err++;
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev.data ||
                               m_axis_tkeep !== prev.keep || m_axis_tlast !== prev.last)) stab_err++;
            got  = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            m_hs = m_axis_tvalid && m_axis_tready;
            if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            if (prev_stall) stall_cycles++;
            prev = got;
            if (m_hs) grant_seen.push_back(int'(grant_ch));
            @(posedge aclk);
            #1;
            cyc++;
            if (m_hs) begin
                out_cyc.push_back(cyc);
                check_beat(got);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (s_hs[c]) begin
                    if (cur_beat[c] == plen[c][cur_pkt[c]] - 1) begin
                        cur_pkt[c]++;
                        cur_beat[c] = 0;
                    end else begin
                        cur_beat[c]++;
                    end
                end
            end
            drive_inputs();
        end
        if (require_done) checkOutput("traffic_complete", traffic_done(), 1);
    endtask

    task automatic reset_dut();
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_s_tready", s_axis_tready, 0);
        checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_m_tlast", m_axis_tlast, 0);
        checkOutput("rst_m_tdata", m_axis_tdata, 0);
        checkOutput("rst_m_tkeep", m_axis_tkeep, 0);
        checkOutput("rst_grant", grant_ch, 0);
        checkOutput("rst_tx_cnt", tx_pkt_cnt, 0);
        checkOutput("rst_trunc_cnt", trunc_cnt, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        cyc           = 0;
        clear_traffic();

        // Single 3-beat packet on channel 0: latency, beats and count.
        $display("[TB] single packet latency");
        reset_dut();
        clear_traffic();
        add_pkt(0, 3);
        build_model();
        applyStimulus(50, 1);
        checkOutput("t1_first_valid_cycle", first_valid_cyc, 2);
        checkOutput("t1_tx_cnt", tx_pkt_cnt, 1);
        checkOutput("t1_grant", grant_ch, 0);

        // All four channels with single-beat packets: grant order and spacing.
        $display("[TB] round robin single beats");
        reset_dut();
        clear_traffic();
        add_pkt(0, 1);
        add_pkt(1, 1);
        add_pkt(2, 1);
        add_pkt(3, 1);
        add_pkt(0, 1);
        build_model();
        applyStimulus(100, 1);
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
        checkOutput("t2_grant_count", grant_seen.size(), 5);
        for (int i = 0; i < 5 && i < grant_seen.size(); i++) begin
            checkOutput("t2_grant_order", grant_seen[i], exp_g[i]);
        end
        for (int i = 1; i < out_cyc.size(); i++) begin
            checkOutput("t2_pkt_spacing", out_cyc[i] - out_cyc[i-1], 2);
        end
        checkOutput("t2_tx_cnt", tx_pkt_cnt, 5);

        // Channel 2 arrives mid-way through channel 1's packet: lock must hold.
        $display("[TB] packet lock");
        reset_dut();
        clear_traffic();
        add_pkt(1, 4);
        add_pkt(2, 2);
        start_cyc[2] = 3;
        build_model();
        applyStimulus(100, 1);
        checkOutput("t3_lock_violations", lock_err, 0);
        checkOutput("t3_tx_cnt", tx_pkt_cnt, 2);

        // Oversize packet is truncated and its tail drained; an exact MAX_BEATS packet is not.
        $display("[TB] truncation and exact length");
        reset_dut();
        clear_traffic();
        add_pkt(0, 6);
        build_model();
        applyStimulus(100, 1);
        checkOutput("t4_trunc_cnt", trunc_cnt, 1);
        checkOutput("t4_tx_cnt", tx_pkt_cnt, 1);
        clear_traffic();
        pid_base = 8;
        add_pkt(0, 4);
        add_pkt(0, 2);
        build_model();
        applyStimulus(100, 1);
        checkOutput("t4_exact_trunc_cnt", trunc_cnt, 1);
        checkOutput("t4_exact_tx_cnt", tx_pkt_cnt, 3);

        // Downstream backpressure pattern 1,0,0,1 with a mid-packet source gap.
        $display("[TB] backpressure");
        reset_dut();
        clear_traffic();
        rdy_mode   = 1;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        add_pkt(0, 3);
        build_model();
        applyStimulus(100, 1);
        checkOutput("t5_stalls_seen", stall_cycles > 0, 1);
        checkOutput("t5_stability_violations", stab_err, 0);
        checkOutput("t5_tx_cnt", tx_pkt_cnt, 1);

        // Reset in the middle of a 5-beat packet, then a fresh packet.
        $display("[TB] reset mid packet");
        reset_dut();
        clear_traffic();
        add_pkt(0, 5);
        build_model();
        applyStimulus(3, 0);
        checkOutput("t6_valid_before_reset", m_axis_tvalid, 1);
        aresetn = 1'b0;
        #1;
        checkOutput("t6_rst_m_tvalid", m_axis_tvalid, 0);
        checkOutput("t6_rst_m_tlast", m_axis_tlast, 0);
        checkOutput("t6_rst_m_tdata", m_axis_tdata, 0);
        checkOutput("t6_rst_s_tready", s_axis_tready, 0);
        checkOutput("t6_rst_grant", grant_ch, 0);
        clear_traffic();
        drive_inputs();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        pid_base = 16;
        add_pkt(0, 2);
        build_model();
        applyStimulus(50, 1);
        checkOutput("t6_tx_cnt", tx_pkt_cnt, 1);
        checkOutput("t6_trunc_cnt", trunc_cnt, 0);

        // Randomised traffic on all channels with source gaps and random backpressure.
        $display("[TB] random traffic");
        reset_dut();
        clear_traffic();
        rdy_mode = 2;
        gap_pct  = 30;
        for (int c = 0; c < NUM_CH; c++) begin
            int n;
            n = int'($urandom_range(2, 4));
            for (int p = 0; p < n; p++) add_pkt(c, int'($urandom_range(1, 6)));
        end
        build_model();
        applyStimulus(4000, 1);
        checkOutput("t7_tx_cnt", tx_pkt_cnt, exp_pkts);
        checkOutput("t7_trunc_cnt", trunc_cnt, exp_trunc);
        checkOutput("t7_lock_violations", lock_err, 0);
        checkOutput("t7_stability_violations", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ernic_tx_pkt_arb.md
Name: ernic_tx_pkt_arb

Overview:
- N-channel AXI-Stream packet arbiter feeding the CMAC TX path.
- Successor to the single-source ERNIC→CMAC hookup; generalised to NUM_CH sources, parametrised width, with packet-locked round-robin, oversize-packet truncation and drain, an output register slice, and statistics counters.
- Sits in the aclk domain in front of the CMAC-side clock-crossing FIFO.

Parameters:
- NUM_CH, 4, number of input channels (2..8)
- DATA_W, 512, tdata width in bits; tkeep width is DATA_W/8
- MAX_BEATS, 144, maximum beats per forwarded packet; longer packets are truncated (≥2)
- CNT_W, 32, width of tx_pkt_cnt

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- s_axis_tkeep  in  NUM_CH*DATA_W/8  per-channel byte enables
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tlast  in  NUM_CH  per-channel end of packet
- s_axis_tready  out  NUM_CH  per-channel ready
- m_axis_tdata  out  DATA_W  merged output data
- m_axis_tkeep  out  DATA_W/8  merged byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output end of packet
- m_axis_tready  in  1  downstream ready
- grant_ch  out  $clog2(NUM_CH)  channel currently owning the output
- tx_pkt_cnt  out  CNT_W  packets emitted on m_axis; wraps
- trunc_cnt  out  16  packets truncated; saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0.
  - grant_ch=0, counters=0, state=IDLE.
  - Round-robin pointer = NUM_CH-1, so channel 0 wins first.
- State machine (states IDLE, FWD, DRAIN):
  - IDLE:
    - All s_axis_tready=0.
    - If any s_axis_tvalid: select the first asserted channel, searching from pointer+1 upward modulo NUM_CH.
    - Register the selection as grant_ch and move the pointer to it.
    - Go to FWD next cycle; beat counter=0.
  - FWD:
    - Only s_axis_tready[grant_ch] may be 1. It equals (!m_axis_tvalid || m_axis_tready); all other channels are 0.
    - An accepted beat loads the output slice on the same edge.
    - m_axis_tlast = s_axis_tlast OR (beat counter == MAX_BEATS-1).
    - Accepted beat with real tlast → IDLE.
    - Accepted MAX_BEATS-th beat without tlast → forced tlast, trunc_cnt++, go to DRAIN.
  - DRAIN:
    - s_axis_tready[grant_ch]=1 unconditionally.
    - Beats are discarded; the output is not touched.
    - Accepted tlast → IDLE.
- Packet lock: grant never changes mid-packet. Other channels keep tvalid and wait, with no data loss.
- Latency:
  - From IDLE, tvalid at cycle T → grant at T+1 → first m_axis_tvalid at T+2 (with downstream ready).
  - Steady-state throughput is 1 beat/cycle.
  - Back-to-back packets lose one cycle per arbitration (IDLE bubble).
- Output slice:
  - Single register, 1 beat deep.
  - m_axis_* stable while tvalid && !tready (AXI rule).
  - The slice clears tvalid on handshake unless it is reloaded on the same edge.
- Counters:
  - tx_pkt_cnt increments on m_axis_tvalid && m_axis_tready && m_axis_tlast; wraps at 2^CNT_W.
  - trunc_cnt saturates.
- Boundary conditions:
  - Single-beat packet (tlast on beat 1) is legal.
  - A packet of exactly MAX_BEATS beats with real tlast is not truncated and is not drained.
  - tvalid dropping mid-packet on the granted channel stalls; the grant is held.
  - A source that deasserts tvalid while in IDLE before grant is simply not served; the pointer still updates.
  - Reset mid-packet discards the partial packet; no output tlast is emitted.

Decomposition:
- Shared package ernic_tx_pkg:
  - state enum {IDLE, FWD, DRAIN}
  - function rr_select(req, ptr), returning the next-requester index
  - KEEP_W = DATA_W/8
- One natural sub-module, axis_reg_slice: the 1-deep output register with handshake, parametrised on DATA_W. The arbiter/FSM stays in ernic_tx_pkt_arb.

Test Plan:
- Reset, then ch0 sends 3 beats with m_axis_tready=1 → m_axis_tvalid first at 2 cycles after ch0 tvalid. Output shows 3 beats, tlast on the 3rd; tx_pkt_cnt=1; grant_ch=0.
- Ch0–3 all hold 1-beat packets continuously → grants in order 0,1,2,3,0. Each packet appears once per 2 cycles; tx_pkt_cnt=5 after 5 packets.
- Ch1 sends a 4-beat packet while ch2 asserts tvalid at beat 2 → ch1 beats remain contiguous. Ch2 is granted only after ch1 tlast; s_axis_tready[2]=0 throughout.
- MAX_BEATS=4, ch0 sends 6 beats → output shows 4 beats with tlast forced on the 4th. Beats 5–6 are accepted and dropped; trunc_cnt=1; tx_pkt_cnt=1.
- m_axis_tready toggles 1,0,0,1 during a 3-beat packet → m_axis_tdata is held stable while stalled; no beat is lost or duplicated; sequence order is preserved.
- aresetn pulsed low mid-packet (beat 2 of 5) → outputs go to 0 immediately. After release, ch0 is served first and a fresh 2-beat packet passes intact.
